// File: rtl/gray_count_sequencer.sv
// gray_count_sequencer: sequences an external gray counter per command and checks its transitions.
module gray_count_sequencer #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_gray,
  output logic             cnt_clear,
  output logic             cnt_enable,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] steps_done,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, steps_q, steps_d;
  logic [WIDTH-1:0] prev_gray_q, cnt_bin, diff;
  logic prev_en_q, prev_clr_q, err_q, err_d, accept, trans_ok, final_ok, monitor;
  assign cmd_ready  = state_q == IDLE;
  assign accept     = cmd_valid && cmd_ready;
  assign cnt_clear  = state_q == CLEAR;
  assign cnt_enable = state_q == RUN && !pause && !abort;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign aborted    = (state_q == CLEAR || state_q == RUN) && abort;
  assign steps_done = steps_q;
  assign err        = err_q;
  assign monitor    = state_q == RUN || state_q == DONE;
  always_comb begin
    cnt_bin = '0;
    for (int i = 0; i < WIDTH; i++) cnt_bin[i] = ^(cnt_gray >> i);
  end
  // A legal step after an enable flips exactly one bit; otherwise the count must hold.
  assign diff     = cnt_gray ^ prev_gray_q;
  assign trans_ok = prev_clr_q ? cnt_gray == '0 :
                    prev_en_q  ? (diff != '0 && (diff & (diff - 1'b1)) == '0) : diff == '0;
  assign final_ok = cnt_bin == len_q[WIDTH-1:0];
  always_comb begin
    len_d   = accept ? cmd_len : len_q;
    steps_d = accept ? '0 : steps_q + LEN_W'(cnt_enable);
    err_d   = accept ? 1'b0 : err_q | (monitor && !trans_ok) | (done && !final_ok);
    state_d = aborted           ? IDLE :
              state_q == IDLE   ? (accept ? CLEAR : IDLE) :
              state_q == CLEAR  ? (len_q != '0 ? RUN : DONE) :
              state_q == RUN    ? ((cnt_enable && steps_d == len_q) ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      steps_q     <= '0;
      err_q       <= 1'b0;
      prev_gray_q <= '0;
      prev_en_q   <= 1'b0;
      prev_clr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      steps_q     <= steps_d;
      err_q       <= err_d;
      prev_gray_q <= cnt_gray;
      prev_en_q   <= cnt_enable;
      prev_clr_q  <= cnt_clear;
    end
  end
endmodule

// File: tb/tb_gray_count_sequencer.sv
// tb_gray_count_sequencer: table-driven check of the sequencer against a faultable gray counter model.
module tb_gray_count_sequencer;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [7:0] cmd_len = '0;
  logic [3:0] g = '0;
  logic cmd_ready, cnt_clear, cnt_enable, busy, done, aborted, err;
  logic [7:0] steps_done;
  int fault = 0;
  int checks = 0, failures = 0;

  gray_count_sequencer #(.WIDTH(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .pause(pause), .abort(abort), .cnt_gray(g), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
    .busy(busy), .done(done), .aborted(aborted), .steps_done(steps_done), .err(err));

  always #5 clk = ~clk;

  function automatic logic [3:0] g2b(input logic [3:0] x);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(x >> i);
    return b;
  endfunction

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Counter model; fault 1 jumps 0001->0010, fault 2 ignores clear.
  always @(posedge clk) begin
    if (cnt_clear && fault != 2) g <= '0;
    else if (cnt_enable) g <= (fault == 1 && g == 4'b0001) ? 4'b0010 : b2g(g2b(g) + 4'd1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int len, pfrom, pn, abt, fault;
    int en, done_c, abort_c, gray, steps, err, err_c;
  } vec_t;

  vec_t v[11];
  int en, clr, dc, ac, ec, gd, sd, ed, dn, rdy, ev, rl;

  initial begin
    //        len pfrom pn abt flt  en dc  ac  gray     st err ec
    v[0]  = '{5,  -1,  0, -1, 0,   5, 7,  -1, 4'b0111, 5, 0, -1};
    v[1]  = '{20, -1,  0, -1, 0,  20, 22, -1, 4'b0110, 20, 0, -1};
    v[2]  = '{6,   4,  3, -1, 0,   6, 11, -1, 4'b0101, 6, 0, -1};
    v[3]  = '{5,  -1,  0, -1, 1,   5, 7,  -1, 4'b0101, 5, 1, 5};
    v[4]  = '{10,  6,  1,  6, 0,   4, -1, 6,  -1,      4, 0, -1};
    v[5]  = '{3,  -1,  0, -1, 2,   3, 5,  -1, 4'b0100, 3, 1, 3};
    v[6]  = '{0,  -1,  0, -1, 0,   0, 2,  -1, 4'b0000, 0, 0, -1};
    v[7]  = '{16, -1,  0, -1, 0,  16, 18, -1, 4'b0000, 16, 0, -1};
    v[8]  = '{1,  -1,  0, -1, 0,   1, 3,  -1, 4'b0001, 1, 0, -1};
    v[9]  = '{5,  -1,  0,  1, 0,   0, -1, 1,  -1,      0, 0, -1};
    v[10] = '{3,   2, 30, 31, 0,   0, -1, 31, -1,      0, 0, -1};

    repeat (2) @(negedge clk);
    #1;
    chk("reset ready", cmd_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset aborted", aborted, 0);
    chk("reset clear", cnt_clear, 0);
    chk("reset enable", cnt_enable, 0);
    chk("reset steps", steps_done, 0);
    chk("reset err", err, 0);
    rst = 1'b0;

    for (int k = 0; k < 11; k++) begin
      fault = v[k].fault;
      en = 0; clr = 0; dc = -1; ac = -1; ec = -1; gd = -1; sd = -1; ed = -1; dn = 0; rdy = -1; ev = -1;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        cmd_valid = (c == 0);
        cmd_len = 8'(v[k].len);
        pause = c >= v[k].pfrom && c < v[k].pfrom + v[k].pn;
        abort = c == v[k].abt;
        #1;
        if (c == 0) chk($sformatf("v%0d ready at accept", k), cmd_ready, 1);
        if (ev >= 0 && c == ev + 1) begin
          rdy = cmd_ready;
          break;
        end
        en += int'(cnt_enable);
        clr += int'(cnt_clear);
        if (c > 0 && err && ec < 0) ec = c;
        if (done) begin
          dn++;
          if (dc < 0) begin dc = c; gd = g; sd = steps_done; ed = err; ev = c; end
        end
        if (aborted && ac < 0) begin ac = c; sd = steps_done; ed = err; ev = c; end
      end
      cmd_valid = 1'b0; pause = 1'b0; abort = 1'b0;
      chk($sformatf("v%0d enables", k), en, v[k].en);
      chk($sformatf("v%0d clears", k), clr, 1);
      chk($sformatf("v%0d done cycle", k), dc, v[k].done_c);
      chk($sformatf("v%0d done pulses", k), dn, v[k].done_c >= 0 ? 1 : 0);
      chk($sformatf("v%0d abort cycle", k), ac, v[k].abort_c);
      chk($sformatf("v%0d steps", k), sd, v[k].steps);
      chk($sformatf("v%0d err at end", k), ed, v[k].err);
      chk($sformatf("v%0d err first cycle", k), ec, v[k].err_c);
      if (v[k].gray >= 0) chk($sformatf("v%0d gray at done", k), gd, v[k].gray);
      chk($sformatf("v%0d ready after", k), rdy, 1);
    end
    fault = 0;

    // cmd_valid held through a whole command, then an immediate re-accept.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 8'd2;
    #1;
    chk("held ready c0", cmd_ready, 1);
    rl = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      #1;
      if (c <= 4) rl += int'(cmd_ready);
      if (c == 4) chk("held done c4", done, 1);
      if (c == 5) chk("held ready c5", cmd_ready, 1);
      if (c == 6) chk("held reaccept clear c6", cnt_clear, 1);
    end
    chk("held ready low while busy", rl, 0);

    // rst in the final RUN cycle must beat completion.
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst-run busy", busy, 1);
    chk("rst-run enable", cnt_enable, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst-run ready", cmd_ready, 1);
    chk("rst-run busy after", busy, 0);
    chk("rst-run done", done, 0);
    chk("rst-run steps", steps_done, 0);
    chk("rst-run err", err, 0);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      dn += int'(done) + int'(aborted);
    end
    chk("rst-run no pulses", dn, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gray_count_sequencer.md
Name: gray_count_sequencer

Overview:
- Command-driven controller that sequences one external WIDTH-bit gray counter.
- On each accepted command it clears the counter, then drives its enable for exactly cmd_len increments, honouring pause and abort.
- It checks every observed gray transition for legality and checks the final count, flagging any mismatch.
- It sits between the test/control logic and the gray counter instance, and owns that counter's enable and clear.

Parameters:
- WIDTH, 4, width of the controlled gray counter.
- LEN_W, 8, width of cmd_len and steps_done. Must satisfy LEN_W >= WIDTH.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE. A command is accepted when cmd_valid && cmd_ready.
- cmd_len  input  LEN_W  number of increments requested; sampled at accept.
- pause  input  1  in RUN, suppresses the increment for that cycle.
- abort  input  1  cancels the command in CLEAR or RUN.
- cnt_gray  input  WIDTH  registered gray output of the controlled counter.
- cnt_clear  output  1  synchronous clear to the counter.
- cnt_enable  output  1  increment enable to the counter.
- busy  output  1  high in CLEAR, RUN and DONE.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse on abort.
- steps_done  output  LEN_W  number of enabled cycles issued for the current or last command.
- err  output  1  sticky error flag; cleared by rst or by the next accept.

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready=1; internal len, step and previous-gray registers are 0.
- A rst asserted mid-operation returns to IDLE on the next edge with no done or aborted pulse.

State machine (IDLE, CLEAR, RUN, DONE), all outputs decoded from registered state:
- IDLE: cmd_ready=1. On accept: latch cmd_len, zero steps_done, clear err, go to CLEAR.
- CLEAR: cnt_clear=1 for exactly one cycle. Next state is RUN if len != 0, otherwise DONE.
- RUN: cnt_enable = !pause && !abort. Each enabled cycle increments steps_done.
  - Go to DONE in the cycle where the enabled increment makes steps_done == len.
  - cnt_enable is never high more than len cycles per command.
- DONE: one cycle; done=1; final check runs; then IDLE. cmd_ready rises the cycle after done.
- Abort:
  - Abort in CLEAR or RUN: go to IDLE next cycle, aborted=1 for that cycle, cnt_enable=0 in the abort cycle, steps_done holds.
  - Abort wins over pause and over completion in the same cycle.
  - Abort in IDLE or DONE is ignored.
- Latency, with no pause: accept at cycle T; cnt_clear at T+1; cnt_enable high at T+2 through T+1+len; done at T+2+len. For len=0, done is at T+2.

Monitor (sets err, sticky):
- Active in RUN and DONE; uses the previous-cycle sample of cnt_gray and cnt_enable/cnt_clear.
- Previous cycle had cnt_clear: cnt_gray must equal 0.
- Previous cycle had cnt_enable: cnt_gray must differ from the previous sample in exactly 1 bit.
- Otherwise: cnt_gray must equal the previous sample.
- Final check in DONE: gray-to-binary(cnt_gray) must equal len mod 2^WIDTH.

Arithmetic and wrap:
- The counter wraps naturally at 2^WIDTH, so len may exceed 2^WIDTH.
- steps_done never wraps within a command, because steps_done <= len < 2^LEN_W.

Boundary conditions:
- pause held throughout RUN: stays in RUN indefinitely with cnt_enable=0 and no err.
- cmd_valid held during busy: ignored until IDLE; cmd_ready is low throughout.
- Back-to-back commands: minimum spacing is DONE followed by 1 IDLE cycle.

Test Plan:
- Accept cmd_len=5, pause=0, correct counter -> cnt_clear 1 cycle, cnt_enable exactly 5 cycles; done at T+7; cnt_gray=0111 (binary 5) in DONE; steps_done=5; err=0.
- cmd_len=20, WIDTH=4 -> gray sequence wraps through 1000->0000; DONE shows binary 4 (gray 0110); err=0.
- cmd_len=6 with pause high for 3 cycles mid-RUN -> cnt_enable total 6 cycles; done at T+11; no err.
- cmd_len=10 with abort after 4 enables, abort and pause both high -> aborted pulse, steps_done=4, no done; cmd_ready=1 next cycle; a new command clears err.
- Fault injection: counter model jumps 0001->0010 (2-bit change) -> err=1 on the next cycle and stays high through done. Separately, a counter model that ignores cnt_clear -> err=1 in the first RUN cycle.
- cmd_len=0 -> cnt_clear 1 cycle, no cnt_enable, done at T+2. Separately, rst asserted in RUN -> outputs return to reset values next edge with no done.
